dcm_clkgen_prog_rx: RTL and testbench
=====================================

# dcm_clkgen_prog_rx

Synthesizable responder for the DCM_CLKGEN serial programming port (PROGEN/PROGDATA/PROGDONE). It sits on the far side of `dcm_clkgen_load` and decodes LoadD, LoadM and GO frames into registered multiplier and divider values. It drives PROGDONE exactly as the Spartan-6 primitive does. It serves two purposes:
- bench model for the clock-management loader;
- front end for targets whose PLL has no native DCM_CLKGEN, where the decoded M/D drive a vendor reconfiguration port.

## Interface
Parameters:
- `DONE_DELAY`, default 16: cycles PROGDONE stays low after GO. Legal range is 2–255.
- `INIT_M1`, default 8'd1: reset value of the active and pending M-1 (M=2).
- `INIT_D1`, default 8'd1: reset value of the active and pending D-1 (D=2).

Ports:
- `clk_i` in 1: programming clock (PROGCLK). This is the only clock.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `progen_i` in 1: PROGEN from the loader.
- `progdata_i` in 1: PROGDATA from the loader, sampled on the rising edge of `clk_i`.
- `progdone_o` out 1: PROGDONE. High when idle; low while an update is applied.
- `mult_m1_o` out 8: active M-1.
- `div_m1_o` out 8: active D-1.
- `applied_o` out 1: one-cycle pulse when the active values update.
- `frame_err_o` out 1: sticky protocol-error flag. Cleared only by reset.
- `err_count_o` out 8: error counter. Present only with `CLKGEN_RX_ERRCNT_EN`.

## Operation
Frame format (all values sampled on the rising edge of `clk_i`):
- LoadD: PROGEN high for exactly 10 cycles. Bits are 1, 0, then D-1 LSB first.
- LoadM: PROGEN high for exactly 10 cycles. Bits are 1, 1, then M-1 LSB first.
- GO: PROGEN high for exactly 1 cycle with PROGDATA=0.
- Every frame ends with PROGEN low for at least one cycle.

State machine: IDLE, SHIFT, GOCHK, DISCARD, BUSY.
- IDLE, PROGEN=1:
  - PROGDATA=1 → SHIFT, bit counter=1.
  - PROGDATA=0 → GOCHK.
- SHIFT:
  - Bit 1 selects the target: 1=M, 0=D.
  - Bits 2..9 fill an 8-bit shift register LSB first.
  - PROGEN low before bit 9 → error, frame dropped, → IDLE.
  - After bit 9, the next sample decides:
    - PROGEN=0 → commit the shift register to `pend_m1` or `pend_d1`, → IDLE.
    - PROGEN=1 → error, → DISCARD.
- GOCHK:
  - PROGEN=0 → BUSY, load delay counter with `DONE_DELAY`-1.
  - PROGEN=1 → error, → DISCARD.
- DISCARD: remain until PROGEN=0, then → IDLE. No register changes.
- BUSY:
  - `progdone_o`=0. The counter decrements each cycle.
  - At 0: `mult_m1_o`←`pend_m1`, `div_m1_o`←`pend_d1`, `applied_o`=1 for one cycle, `progdone_o`=1, → IDLE.
  - PROGEN=1 in any BUSY cycle → error. BUSY continues and the countdown is unaffected. The offending frame is ignored: from the cycle after the countdown ends, the FSM behaves as DISCARD until PROGEN=0.
- Error pulse: every error sets `frame_err_o` and increments the counter (when present) in the same cycle.
- GO with no preceding Load re-applies the current pending values. This is legal, not an error.
- Pending registers are not cleared by GO. Later frames overwrite them individually.

Reset values:
- `progdone_o`=1.
- `applied_o`=0.
- `frame_err_o`=0.
- `mult_m1_o`=`pend_m1`=`INIT_M1`.
- `div_m1_o`=`pend_d1`=`INIT_D1`.
- `err_count_o`=0.
- FSM=IDLE.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Load frame: first bit sampled at edge N → pending register valid after edge N+10.
- GO: GO bit at edge N, PROGEN low at edge N+1.
  - `progdone_o` falls after edge N+1.
  - `progdone_o` rises, outputs update and `applied_o` pulses after edge N+1+`DONE_DELAY`.
- Back-to-back frames with a one-cycle PROGEN-low gap are accepted at full rate.
- A reset mid-frame or mid-BUSY discards all state. Outputs return to reset values on that edge, and the interrupted GO never applies.

## Configuration
- `CLKGEN_RX_ERRCNT_EN` defined:
  - `err_count_o` is present: an 8-bit counter, +1 per protocol error, saturating at 255, reset to 0.
- Not defined:
  - The port and counter are omitted.
  - `frame_err_o` alone reports errors; all other behaviour is identical.

## Test plan
- After reset, drive nothing → `progdone_o`=1, `mult_m1_o`=1, `div_m1_o`=1, no `applied_o` pulse for 100 cycles.
- Send LoadD(D-1=0x04), then LoadM(M-1=0x09), then GO → `progdone_o` low for exactly 16 cycles; then `div_m1_o`=0x04, `mult_m1_o`=0x09, one `applied_o` pulse, `frame_err_o`=0.
- Send LoadM with PROGEN held for 11 cycles, then GO → `frame_err_o`=1, error count=1, `mult_m1_o` stays 0x01 after apply.
- Send LoadD with PROGEN dropped after 6 bits → error count=1, `pend_d1` unchanged, a following valid frame still decodes.
- Assert PROGEN during BUSY → error count +1, `progdone_o` still rises exactly `DONE_DELAY` cycles after GO, pending values unchanged.
- Pull `reset_n_i` low at BUSY cycle 5 → next edge `progdone_o`=1, `mult_m1_o`/`div_m1_o` at INIT values, `applied_o` never pulses.

Source files
------------

// File: rtl/dcm_clkgen_prog_rx.sv
// rtl/dcm_clkgen_prog_rx.sv - DCM_CLKGEN PROGEN/PROGDATA/PROGDONE responder decoding LoadD/LoadM/GO into M-1/D-1
// Optional error counter port err_count_o is built when CLKGEN_RX_ERRCNT_EN is defined.
module dcm_clkgen_prog_rx #(
  parameter int unsigned DONE_DELAY = 16,
  parameter logic [7:0]  INIT_M1    = 8'd1,
  parameter logic [7:0]  INIT_D1    = 8'd1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       progen_i,
  input  logic       progdata_i,
  output logic       progdone_o,
  output logic [7:0] mult_m1_o,
  output logic [7:0] div_m1_o,
  output logic       applied_o,
`ifdef CLKGEN_RX_ERRCNT_EN
  output logic       frame_err_o,
  output logic [7:0] err_count_o
`else
  output logic       frame_err_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GOCHK,
    S_DISCARD,
    S_BUSY
  } state_t;

  localparam logic [7:0] DLY_LOAD = 8'(DONE_DELAY - 1);

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift_q, shift_n;
  logic       tgt_m, tgt_m_n;
  logic [7:0] dly_cnt, dly_cnt_n;
  logic [7:0] pend_m1, pend_d1;
  logic       progen_q;
  logic       err, commit, apply, start_busy;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_q;
    tgt_m_n    = tgt_m;
    dly_cnt_n  = dly_cnt;
    err        = 1'b0;
    commit     = 1'b0;
    apply      = 1'b0;
    start_busy = 1'b0;
    case (state)
      S_IDLE: begin
        if (progen_i) begin
          if (progdata_i) begin
            state_n   = S_SHIFT;
            bit_cnt_n = 4'd1;
          end else begin
            state_n = S_GOCHK;
          end
        end
      end
      S_SHIFT: begin
        // bit_cnt == 10 means all ten frame bits are in; this sample is the terminator
        if (bit_cnt == 4'd10) begin
          if (progen_i) begin
            err     = 1'b1;
            state_n = S_DISCARD;
          end else begin
            commit  = 1'b1;
            state_n = S_IDLE;
          end
        end else if (!progen_i) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end else begin
          if (bit_cnt == 4'd1) tgt_m_n = progdata_i;
          else                 shift_n = {progdata_i, shift_q[7:1]};
          bit_cnt_n = bit_cnt + 4'd1;
        end
      end
      S_GOCHK: begin
        if (progen_i) begin
          err     = 1'b1;
          state_n = S_DISCARD;
        end else begin
          start_busy = 1'b1;
          dly_cnt_n  = DLY_LOAD;
          state_n    = S_BUSY;
        end
      end
      S_DISCARD: begin
        if (!progen_i) state_n = S_IDLE;
      end
      S_BUSY: begin
        // one error per intruding frame; the countdown itself is never disturbed
        err = progen_i && !progen_q;
        if (dly_cnt == 8'd0) begin
          apply   = 1'b1;
          state_n = progen_i ? S_DISCARD : S_IDLE;
        end else begin
          dly_cnt_n = dly_cnt - 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shift_q  <= 8'd0;
      tgt_m    <= 1'b0;
      dly_cnt  <= 8'd0;
      progen_q <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift_q  <= shift_n;
      tgt_m    <= tgt_m_n;
      dly_cnt  <= dly_cnt_n;
      progen_q <= progen_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pend_m1     <= INIT_M1;
      pend_d1     <= INIT_D1;
      mult_m1_o   <= INIT_M1;
      div_m1_o    <= INIT_D1;
      progdone_o  <= 1'b1;
      applied_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      applied_o   <= apply;
      frame_err_o <= frame_err_o | err;
      if (commit) begin
        if (tgt_m) pend_m1 <= shift_q;
        else       pend_d1 <= shift_q;
      end
      if (start_busy) progdone_o <= 1'b0;
      if (apply) begin
        progdone_o <= 1'b1;
        mult_m1_o  <= pend_m1;
        div_m1_o   <= pend_d1;
      end
    end
  end

`ifdef CLKGEN_RX_ERRCNT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                       err_count_o <= 8'd0;
    else if (err && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dcm_clkgen_prog_rx.sv
// tb/tb_dcm_clkgen_prog_rx.sv - directed self-checking bench for dcm_clkgen_prog_rx
module tb_dcm_clkgen_prog_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       progen = 1'b0;
  logic       progdata = 1'b0;
  logic       progdone;
  logic [7:0] mult_m1;
  logic [7:0] div_m1;
  logic       applied;
  logic       frame_err;
`ifdef CLKGEN_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dcm_clkgen_prog_rx #(.DONE_DELAY(16), .INIT_M1(8'd1), .INIT_D1(8'd1)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .progen_i    (progen),
    .progdata_i  (progdata),
    .progdone_o  (progdone),
    .mult_m1_o   (mult_m1),
    .div_m1_o    (div_m1),
    .applied_o   (applied),
`ifdef CLKGEN_RX_ERRCNT_EN
    .frame_err_o (frame_err),
    .err_count_o (err_count)
`else
    .frame_err_o (frame_err)
`endif
  );

  task automatic tick(input logic en, input logic d);
    progen = en;
    progdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_load(input logic is_m, input logic [7:0] v);
    tick(1'b1, 1'b1);
    tick(1'b1, is_m);
    for (int i = 0; i < 8; i++) tick(1'b1, v[i]);
    tick(1'b0, 1'b0);
  endtask

  task automatic send_go;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  // Starts right after the GO terminator edge; counts cycles with progdone low and applied pulses.
  task automatic busy_run(input logic [39:0] en_pat, input logic [39:0] dat_pat,
                          output int lows, output int pulses);
    lows = 0;
    pulses = 0;
    while (progdone == 1'b0 && lows < 40) begin
      tick(en_pat[lows], dat_pat[lows]);
      lows++;
      if (applied) pulses++;
    end
  endtask

  task automatic test_reset;
    int pulses = 0;
    int lows = 0;
    do_reset();
    total++; if (progdone !== 1'b1) begin bad++; $display("FAIL reset_progdone got=%0h want=1", progdone); end
    total++; if (mult_m1 !== 8'h01) begin bad++; $display("FAIL reset_mult got=%0h want=01", mult_m1); end
    total++; if (div_m1 !== 8'h01) begin bad++; $display("FAIL reset_div got=%0h want=01", div_m1); end
    total++; if (applied !== 1'b0) begin bad++; $display("FAIL reset_applied got=%0h want=0", applied); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%0h want=0", frame_err); end
`ifdef CLKGEN_RX_ERRCNT_EN
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got=%0h want=0", err_count); end
`endif
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0);
      if (applied) pulses++;
      if (!progdone) lows++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL idle_applied got=%0d want=0", pulses); end
    total++; if (lows !== 0) begin bad++; $display("FAIL idle_progdone_low got=%0d want=0", lows); end
  endtask

  task automatic test_load_go;
    int lows, pulses;
    send_load(1'b0, 8'h04);
    send_load(1'b1, 8'h09);
    send_go();
    total++; if (progdone !== 1'b0) begin bad++; $display("FAIL go_progdone_fall got=%0h want=0", progdone); end
    total++; if (div_m1 !== 8'h01) begin bad++; $display("FAIL go_div_early got=%0h want=01", div_m1); end
    busy_run('0, '0, lows, pulses);
    total++; if (lows !== 16) begin bad++; $display("FAIL go_low_cycles got=%0d want=16", lows); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL go_applied_pulses got=%0d want=1", pulses); end
    total++; if (applied !== 1'b1) begin bad++; $display("FAIL go_applied_with_rise got=%0h want=1", applied); end
    total++; if (div_m1 !== 8'h04) begin bad++; $display("FAIL go_div got=%0h want=04", div_m1); end
    total++; if (mult_m1 !== 8'h09) begin bad++; $display("FAIL go_mult got=%0h want=09", mult_m1); end
    tick(1'b0, 1'b0);
    total++; if (applied !== 1'b0) begin bad++; $display("FAIL go_applied_one_cycle got=%0h want=0", applied); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL go_frame_err got=%0h want=0", frame_err); end
  endtask

  task automatic test_back_to_back;
    int lows, pulses;
    send_load(1'b1, 8'hA5);
    send_load(1'b0, 8'h3C);
    send_go();
    busy_run('0, '0, lows, pulses);
    total++; if (mult_m1 !== 8'hA5) begin bad++; $display("FAIL b2b_mult got=%0h want=a5", mult_m1); end
    total++; if (div_m1 !== 8'h3C) begin bad++; $display("FAIL b2b_div got=%0h want=3c", div_m1); end
    total++; if (lows !== 16) begin bad++; $display("FAIL b2b_low_cycles got=%0d want=16", lows); end
  endtask

  task automatic test_overlong;
    int lows, pulses;
    logic [7:0] v = 8'h5A;
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, v[i]);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL long_err_early got=%0h want=0", frame_err); end
    tick(1'b1, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL long_frame_err got=%0h want=1", frame_err); end
    tick(1'b0, 1'b0);
    send_go();
    busy_run('0, '0, lows, pulses);
    total++; if (mult_m1 !== 8'h01) begin bad++; $display("FAIL long_mult got=%0h want=01", mult_m1); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL long_applied got=%0d want=1", pulses); end
`ifdef CLKGEN_RX_ERRCNT_EN
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL long_err_count got=%0d want=1", err_count); end
`endif
  endtask

  task automatic test_short;
    int lows, pulses;
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_frame_err got=%0h want=1", frame_err); end
    send_go();
    busy_run('0, '0, lows, pulses);
    total++; if (div_m1 !== 8'h01) begin bad++; $display("FAIL short_pend_d got=%0h want=01", div_m1); end
    send_load(1'b0, 8'h37);
    send_go();
    busy_run('0, '0, lows, pulses);
    total++; if (div_m1 !== 8'h37) begin bad++; $display("FAIL short_recover_div got=%0h want=37", div_m1); end
    total++; if (mult_m1 !== 8'h01) begin bad++; $display("FAIL short_recover_mult got=%0h want=01", mult_m1); end
`ifdef CLKGEN_RX_ERRCNT_EN
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL short_err_count got=%0d want=1", err_count); end
`endif
  endtask

  task automatic test_busy_intrude;
    int lows, pulses;
    logic [39:0] en_pat = '0;
    logic [39:0] dat_pat = '0;
    logic [7:0]  v = 8'h55;
    do_reset();
    send_load(1'b1, 8'h22);
    send_go();
    for (int k = 3; k <= 12; k++) en_pat[k] = 1'b1;
    dat_pat[3] = 1'b1;
    for (int k = 5; k <= 12; k++) dat_pat[k] = v[k-5];
    busy_run(en_pat, dat_pat, lows, pulses);
    total++; if (lows !== 16) begin bad++; $display("FAIL intrude_low_cycles got=%0d want=16", lows); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL intrude_frame_err got=%0h want=1", frame_err); end
    total++; if (mult_m1 !== 8'h22) begin bad++; $display("FAIL intrude_mult got=%0h want=22", mult_m1); end
    total++; if (div_m1 !== 8'h01) begin bad++; $display("FAIL intrude_div got=%0h want=01", div_m1); end
    tick(1'b0, 1'b0);
    send_go();
    busy_run('0, '0, lows, pulses);
    total++; if (div_m1 !== 8'h01) begin bad++; $display("FAIL intrude_pend_d got=%0h want=01", div_m1); end
    total++; if (mult_m1 !== 8'h22) begin bad++; $display("FAIL reapply_mult got=%0h want=22", mult_m1); end
`ifdef CLKGEN_RX_ERRCNT_EN
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL intrude_err_count got=%0d want=1", err_count); end
`endif
  endtask

  task automatic test_reset_mid_busy;
    int pulses = 0;
    int lows = 0;
    do_reset();
    send_load(1'b1, 8'h33);
    send_load(1'b0, 8'h44);
    send_go();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    total++; if (progdone !== 1'b0) begin bad++; $display("FAIL rstbusy_in_busy got=%0h want=0", progdone); end
    reset_n = 1'b0;
    tick(1'b0, 1'b0);
    total++; if (progdone !== 1'b1) begin bad++; $display("FAIL rstbusy_progdone got=%0h want=1", progdone); end
    total++; if (mult_m1 !== 8'h01) begin bad++; $display("FAIL rstbusy_mult got=%0h want=01", mult_m1); end
    total++; if (div_m1 !== 8'h01) begin bad++; $display("FAIL rstbusy_div got=%0h want=01", div_m1); end
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0);
      if (applied) pulses++;
      if (!progdone) lows++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rstbusy_applied got=%0d want=0", pulses); end
    total++; if (lows !== 0) begin bad++; $display("FAIL rstbusy_low got=%0d want=0", lows); end
    total++; if (mult_m1 !== 8'h01) begin bad++; $display("FAIL rstbusy_mult_after got=%0h want=01", mult_m1); end
  endtask

  initial begin
    test_reset();
    test_load_go();
    test_back_to_back();
    test_overlong();
    test_short();
    test_busy_intrude();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
